// File: rtl/race_game_pkg.sv
// Shared types for the race game engine: FSM states, event codes and the
// board event table.
package race_game_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT_DICE,
      S_MOVE,
      S_CHECK,
      S_EVENT,
      S_NEXT,
      S_WIN
   } state_e;

   typedef enum logic [3:0] {
      EVT_NONE  = 4'd0,
      EVT_HOLD  = 4'd1,
      EVT_BACK  = 4'd2,
      EVT_BONUS = 4'd3
   } evt_e;

   function automatic evt_e evt_lookup(input logic [3:0] square);
      evt_e code;
      case (square)
         4'd2:    code = EVT_HOLD;
         4'd3:    code = EVT_BACK;
         4'd5:    code = EVT_BONUS;
         default: code = EVT_NONE;
      endcase
      return code;
   endfunction

endpackage

// File: rtl/race_turn_timer.sv
// Per-throw countdown: a tick prescaler feeding a seconds counter.
// expire is raised while enabled with no seconds left.
module race_turn_timer #(
   parameter int TICKS_PER_SEC = 100_000_000,
   parameter int TIMEOUT_SEC   = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       reload,
   input  logic       en,
   output logic [3:0] time_left,
   output logic       expire
);

   localparam int TW = $clog2(TICKS_PER_SEC + 1);
   localparam logic [TW-1:0] TMAX = TW'(TICKS_PER_SEC - 1);

   logic [TW-1:0] tick;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tick      <= '0;
         time_left <= '0;
      end else if (reload) begin
         tick      <= '0;
         time_left <= 4'(TIMEOUT_SEC);
      end else if (en && time_left != 4'd0) begin
         if (tick == TMAX) begin
            tick      <= '0;
            time_left <= time_left - 4'd1;
         end else begin
            tick <= tick + 1'b1;
         end
      end
   end

   assign expire = en && (time_left == 4'd0);

endmodule

// File: rtl/race_game_engine.sv
// Board race game controller: dice-driven moves, square events and winner.
// Define RACE_TIMEOUT_EN to enable the per-throw timeout.
module race_game_engine #(
   parameter int NUM_PLAYERS   = 2,
   parameter int BOARD_LEN     = 10,
   parameter int DICE_W        = 2,
   parameter int TICKS_PER_SEC = 100_000_000,
   parameter int TIMEOUT_SEC   = 8,
   localparam int POS_W        = $clog2(BOARD_LEN + 1),
   localparam int PID_W        = $clog2(NUM_PLAYERS)
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         start_btn,
   input  logic                         dice_valid,
   input  logic [DICE_W-1:0]            dice_value,
   input  logic                         evt_done,
   output logic [NUM_PLAYERS*POS_W-1:0] pos_flat,
   output logic [PID_W-1:0]             turn,
   output logic                         pos_valid,
   output logic [3:0]                   event_flag,
   output logic                         winner_valid,
   output logic [PID_W-1:0]             winner_id,
   output logic [3:0]                   time_left
);

   import race_game_pkg::*;

   localparam int SUM_W = POS_W + DICE_W + 1;

   state_e            state;
   logic [POS_W-1:0]  pos [NUM_PLAYERS];
   logic [DICE_W-1:0] dice_lat;
   logic              bonus_pend;
   logic [SUM_W-1:0]  sum;
   logic [POS_W-1:0]  next_pos;
   evt_e              cur_evt;
   logic              t_reload;
   logic              t_en;
   logic              expire;

   assign sum = SUM_W'(pos[turn]) + SUM_W'(dice_lat);

   always_comb begin
      next_pos = sum[POS_W-1:0];
      if (sum > SUM_W'(BOARD_LEN))
         next_pos = POS_W'(BOARD_LEN);
   end

   assign cur_evt = evt_lookup(4'(pos[turn]));

   for (genvar k = 0; k < NUM_PLAYERS; k++) begin : g_flat
      assign pos_flat[k*POS_W +: POS_W] = pos[k];
   end

`ifdef RACE_TIMEOUT_EN
   assign t_reload = (state == S_IDLE && start_btn) || state == S_NEXT;
   assign t_en     = (state == S_WAIT_DICE);
`else
   assign t_reload = 1'b0;
   assign t_en     = 1'b0;
`endif

   race_turn_timer #(
      .TICKS_PER_SEC (TICKS_PER_SEC),
      .TIMEOUT_SEC   (TIMEOUT_SEC)
   ) u_timer (
      .clk       (clk),
      .reset     (reset),
      .reload    (t_reload),
      .en        (t_en),
      .time_left (time_left),
      .expire    (expire)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= S_IDLE;
         for (int k = 0; k < NUM_PLAYERS; k++) pos[k] <= '0;
         turn         <= '0;
         dice_lat     <= '0;
         bonus_pend   <= 1'b0;
         pos_valid    <= 1'b0;
         event_flag   <= '0;
         winner_valid <= 1'b0;
         winner_id    <= '0;
      end else begin
         pos_valid <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start_btn) begin
                  for (int k = 0; k < NUM_PLAYERS; k++) pos[k] <= '0;
                  turn       <= '0;
                  bonus_pend <= 1'b0;
                  state      <= S_WAIT_DICE;
               end
            end
            // a valid throw takes priority over a coincident expiry
            S_WAIT_DICE: begin
               if (dice_valid && dice_value != '0) begin
                  dice_lat <= dice_value;
                  state    <= S_MOVE;
               end else if (expire) begin
                  state <= S_NEXT;
               end
            end
            S_MOVE: begin
               pos[turn] <= next_pos;
               pos_valid <= 1'b1;
               state     <= S_CHECK;
            end
            S_CHECK: begin
               if (pos[turn] == POS_W'(BOARD_LEN)) begin
                  winner_valid <= 1'b1;
                  winner_id    <= turn;
                  state        <= S_WIN;
               end else if (cur_evt != EVT_NONE) begin
                  event_flag <= cur_evt;
                  state      <= S_EVENT;
               end else begin
                  state <= S_NEXT;
               end
            end
            S_EVENT: begin
               if (evt_done) begin
                  if (event_flag == EVT_BACK)  pos[turn]  <= '0;
                  if (event_flag == EVT_BONUS) bonus_pend <= 1'b1;
                  event_flag <= '0;
                  state      <= S_NEXT;
               end
            end
            S_NEXT: begin
               if (!bonus_pend)
                  turn <= (turn == PID_W'(NUM_PLAYERS - 1)) ? '0 : turn + 1'b1;
               bonus_pend <= 1'b0;
               state      <= S_WAIT_DICE;
            end
            S_WIN: begin
               if (start_btn) begin
                  for (int k = 0; k < NUM_PLAYERS; k++) pos[k] <= '0;
                  winner_valid <= 1'b0;
                  winner_id    <= '0;
                  state        <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_race_game_engine.sv
// Directed bench for race_game_engine: throw table plus hand sequences
// for stray inputs, win/restart, reset during an event and the timeout.
module tb_race_game_engine;

   localparam int NP    = 3;
   localparam int POS_W = 4;
   localparam int PID_W = 2;

   logic              clk = 1'b0;
   logic              reset;
   logic              start_btn;
   logic              dice_valid;
   logic [1:0]        dice_value;
   logic              evt_done;
   logic [NP*POS_W-1:0] pos_flat;
   logic [PID_W-1:0]  turn;
   logic              pos_valid;
   logic [3:0]        event_flag;
   logic              winner_valid;
   logic [PID_W-1:0]  winner_id;
   logic [3:0]        time_left;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   race_game_engine #(
      .NUM_PLAYERS   (NP),
      .BOARD_LEN     (10),
      .DICE_W        (2),
      .TICKS_PER_SEC (4),
      .TIMEOUT_SEC   (3)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .start_btn    (start_btn),
      .dice_valid   (dice_valid),
      .dice_value   (dice_value),
      .evt_done     (evt_done),
      .pos_flat     (pos_flat),
      .turn         (turn),
      .pos_valid    (pos_valid),
      .event_flag   (event_flag),
      .winner_valid (winner_valid),
      .winner_id    (winner_id),
      .time_left    (time_left)
   );

   typedef struct {
      int mover;
      int dice;
      int mid;
      int evt;
      int hold;
      int fin;
      int nturn;
      int win;
   } vec_t;

   vec_t v [16];

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic int getpos(input int k);
      return int'(pos_flat[k*POS_W +: POS_W]);
   endfunction

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic run_vec(input vec_t t);
      check("turn_before", int'(turn), t.mover);
      dice_valid = 1'b1;
      dice_value = 2'(t.dice);
      step();
      dice_valid = 1'b0;
      check("pv_early", int'(pos_valid), 0);
      step();
      check("pv_pulse", int'(pos_valid), 1);
      check("mid_pos", getpos(t.mover), t.mid);
      step();
      check("pv_clear", int'(pos_valid), 0);
      if (t.win != 0) begin
         check("winner_valid", int'(winner_valid), 1);
         check("winner_id", int'(winner_id), t.mover);
      end else if (t.evt != 0) begin
         check("event_flag", int'(event_flag), t.evt);
         for (int h = 0; h < t.hold; h++) begin
            dice_valid = 1'b1;
            dice_value = 2'd3;
            step();
         end
         dice_valid = 1'b0;
         if (t.hold > 0) begin
            check("evt_held", int'(event_flag), t.evt);
            check("evt_held_turn", int'(turn), t.mover);
         end
         evt_done = 1'b1;
         step();
         evt_done = 1'b0;
         check("evt_cleared", int'(event_flag), 0);
         step();
      end else begin
         step();
      end
      check("final_pos", getpos(t.mover), t.fin);
      check("next_turn", int'(turn), t.nturn);
   endtask

   initial begin
      v[0]  = '{0, 1, 1,  0, 0,  1,  1, 0};
      v[1]  = '{1, 2, 2,  1, 2,  2,  2, 0};
      v[2]  = '{2, 1, 1,  0, 0,  1,  0, 0};
      v[3]  = '{0, 2, 3,  2, 10, 0,  1, 0};
      v[4]  = '{1, 3, 5,  3, 1,  5,  1, 0};
      v[5]  = '{1, 1, 6,  0, 0,  6,  2, 0};
      v[6]  = '{2, 3, 4,  0, 0,  4,  0, 0};
      v[7]  = '{0, 1, 1,  0, 0,  1,  1, 0};
      v[8]  = '{1, 1, 7,  0, 0,  7,  2, 0};
      v[9]  = '{2, 3, 7,  0, 0,  7,  0, 0};
      v[10] = '{0, 1, 2,  1, 0,  2,  1, 0};
      v[11] = '{1, 1, 8,  0, 0,  8,  2, 0};
      v[12] = '{2, 2, 9,  0, 0,  9,  0, 0};
      v[13] = '{0, 1, 3,  2, 0,  0,  1, 0};
      v[14] = '{1, 1, 9,  0, 0,  9,  2, 0};
      v[15] = '{2, 3, 10, 0, 0,  10, 2, 1};

      reset = 1'b1;
      start_btn = 1'b0;
      dice_valid = 1'b0;
      dice_value = 2'd0;
      evt_done = 1'b0;
      step();
      step();
      check("rst_pos", int'(pos_flat), 0);
      check("rst_turn", int'(turn), 0);
      check("rst_pv", int'(pos_valid), 0);
      check("rst_evt", int'(event_flag), 0);
      check("rst_wv", int'(winner_valid), 0);
      check("rst_wid", int'(winner_id), 0);
      check("rst_tl", int'(time_left), 0);
      reset = 1'b0;
      step();

      start_btn = 1'b1;
      step();
      start_btn = 1'b0;

      for (int i = 0; i < 16; i++) begin
         run_vec(v[i]);
         if (i == 0) begin
            start_btn = 1'b1;
            evt_done = 1'b1;
            step();
            start_btn = 1'b0;
            evt_done = 1'b0;
            check("start_ignored_pos", getpos(0), 1);
            dice_valid = 1'b1;
            dice_value = 2'd0;
            step();
            dice_valid = 1'b0;
            check("dice0_pv", int'(pos_valid), 0);
            step();
            check("dice0_pv2", int'(pos_valid), 0);
            check("dice0_pos", getpos(1), 0);
            check("dice0_turn", int'(turn), 1);
         end
      end

      step();
      step();
      check("win_hold_wv", int'(winner_valid), 1);
      check("win_hold_pos", getpos(2), 10);
      start_btn = 1'b1;
      step();
      start_btn = 1'b0;
      check("restart_pos", int'(pos_flat), 0);
      check("restart_wv", int'(winner_valid), 0);

      start_btn = 1'b1;
      step();
      start_btn = 1'b0;
      run_vec(v[0]);
      dice_valid = 1'b1;
      dice_value = 2'd2;
      step();
      dice_valid = 1'b0;
      step();
      step();
      check("pre_rst_evt", int'(event_flag), 1);
      #2 reset = 1'b1;
      #1;
      check("mid_rst_evt", int'(event_flag), 0);
      check("mid_rst_pos", int'(pos_flat), 0);
      check("mid_rst_turn", int'(turn), 0);
      @(negedge clk);
      reset = 1'b0;
      evt_done = 1'b1;
      step();
      evt_done = 1'b0;
      check("post_rst_pv", int'(pos_valid), 0);
      check("post_rst_evt", int'(event_flag), 0);
      check("post_rst_tl", int'(time_left), 0);

      start_btn = 1'b1;
      step();
      start_btn = 1'b0;
`ifdef RACE_TIMEOUT_EN
      for (int c = 0; c <= 12; c++) begin
         check("tl_count", int'(time_left), c < 4 ? 3 : c < 8 ? 2 : c < 12 ? 1 : 0);
         step();
      end
      step();
      check("to_turn", int'(turn), 1);
      check("to_reload", int'(time_left), 3);
      repeat (12) step();
      check("to_zero", int'(time_left), 0);
      dice_valid = 1'b1;
      dice_value = 2'd1;
      step();
      dice_valid = 1'b0;
      step();
      check("to_dice_pv", int'(pos_valid), 1);
      check("to_dice_pos", getpos(1), 1);
      step();
      step();
      check("to_dice_turn", int'(turn), 2);
`else
      repeat (20) step();
      check("no_to_tl", int'(time_left), 0);
      check("no_to_turn", int'(turn), 0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
